// File: rtl/ioctl_sdram_loader.sv
// Buffers data_io download bytes in a small FIFO and issues them as SDRAM writes.
// Optional LOADER_CHECKSUM_EN adds a 16-bit running sum of committed bytes.
module ioctl_sdram_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [22:0] ROM_BASE   = 23'h000000,
    parameter logic [22:0] AUX_BASE   = 23'h400000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic [7:0]  ioctl_index,
    input  logic        ram_ready,
    output logic [22:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        load_active,
    output logic        load_done,
    output logic        overflow,
    output logic [23:0] bytes_written
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

    state_e        state_q, state_d;
    logic [30:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ram_we_q, ram_we_d;
    logic [22:0]   ram_addr_q, ram_addr_d;
    logic [7:0]    ram_din_q, ram_din_d;
    logic          overflow_q, overflow_d;
    logic [23:0]   bw_q, bw_d;
    logic          dl_q, armed_q, armed_d;

    logic          fifo_empty, fifo_full;
    logic          push, push_ok, pop, drop, commit, dl_rise;
    logic [22:0]   push_addr;
    logic [30:0]   head;

    assign push_addr  = ioctl_addr + ((ioctl_index == 8'd0) ? ROM_BASE : AUX_BASE);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCnt);
    assign head       = mem_q[rd_ptr_q];

    assign push    = ioctl_wr & ioctl_download;
    // A full FIFO still accepts when the FSM pops the head in the same cycle.
    assign push_ok = push & (~fifo_full | pop);
    assign drop    = push & ~push_ok;
    assign dl_rise = ioctl_download & ~dl_q;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        commit     = 1'b0;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = head[30:8];
                    ram_din_d  = head[7:0];
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (ram_ready) begin
                    commit   = 1'b1;
                    ram_we_d = 1'b0;
                    state_d  = StGap;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        bw_d = dl_rise ? '0 : bw_q;
        if (commit && (bw_d != '1)) begin
            bw_d = bw_d + 24'd1;
        end
    end

    assign overflow_d = drop | (overflow_q & ~dl_rise);

    assign load_done = armed_q & ~ioctl_download & fifo_empty & (state_q == StIdle);

    always_comb begin
        armed_d = armed_q;
        if (load_done) begin
            armed_d = 1'b0;
        end
        if (dl_rise) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            overflow_q <= 1'b0;
            bw_q       <= '0;
            dl_q       <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            overflow_q <= overflow_d;
            bw_q       <= bw_d;
            dl_q       <= ioctl_download;
            armed_q    <= armed_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: count_q alone decides which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_addr, ioctl_data};
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = dl_rise ? '0 : csum_q;
        if (commit) begin
            csum_d = csum_d + {8'h00, ram_din_q};
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

    assign ram_we        = ram_we_q;
    assign ram_addr      = ram_addr_q;
    assign ram_din       = ram_din_q;
    assign overflow      = overflow_q;
    assign bytes_written = bw_q;
    // Gated so the mux select drops the instant reset asserts, even mid-download.
    assign load_active   = reset_n & (ioctl_download | ~fifo_empty | (state_q != StIdle));

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed and randomized checks of ioctl_sdram_loader against a queue-based write model.
module tb_ioctl_sdram_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [22:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [7:0]  ioctl_index = '0;
    logic        ram_ready = 1'b0;
    logic [22:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        load_active;
    logic        load_done;
    logic        overflow;
    logic [23:0] bytes_written;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum;
    int unsigned sum_model = 0;
    logic [15:0] csum_at = '0;
`endif

    typedef struct packed {
        logic [22:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  commits = 0;

    ioctl_sdram_loader dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_index    (ioctl_index),
        .ram_ready      (ram_ready),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_we         (ram_we),
        .load_active    (load_active),
        .load_done      (load_done),
        .overflow       (overflow),
        .bytes_written  (bytes_written)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Target address from the file offset and slot, modulo the 8 MB SDRAM space.
    function automatic logic [22:0] model_addr(input logic [22:0] a, input logic [7:0] idx);
        int unsigned base = (idx == 8'd0) ? 32'h000000 : 32'h400000;
        int unsigned sum = (32'(a) + base) % 32'h800000;
        return sum[22:0];
    endfunction

    // Every committed SDRAM write must match the oldest accepted strobe.
    always @(negedge clk_sys) begin
        if (reset_n && ram_we && ram_ready) begin
            wr_t e;
            commits++;
            chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("commit_addr", 32'(ram_addr), 32'(e.a));
                chk("commit_data", 32'(ram_din), 32'(e.d));
`ifdef LOADER_CHECKSUM_EN
                sum_model = (sum_model + 32'(e.d)) % 32'h10000;
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [22:0] a, input logic [7:0] d, input logic [7:0] idx,
                          input bit accept);
        ioctl_wr    = 1'b1;
        ioctl_addr  = a;
        ioctl_data  = d;
        ioctl_index = idx;
        if (accept) exp_q.push_back({model_addr(a, idx), d});
    endtask

    task automatic start_load();
        tick();
        ioctl_download = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum_model = 0;
`endif
    endtask

    task automatic finish_load(input string tag, input int exp_bw);
        int pulses = 0;
        logic [23:0] bw_at = '0;
        tick();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        ram_ready      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            if (load_done) begin
                pulses++;
                bw_at = bytes_written;
`ifdef LOADER_CHECKSUM_EN
                csum_at = checksum;
                chk({tag, "_csum_model"}, 32'(checksum), sum_model);
`endif
            end
        end
        chk({tag, "_done_pulses"}, 32'(pulses), 32'd1);
        chk({tag, "_bytes_written"}, 32'(bw_at), 32'(exp_bw));
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int c;
        int n;
        int c0;
        int t[3];
        bit la_drop;
        bit early;

        // Reset values
        #2;
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_din", 32'(ram_din), 32'd0);
        chk("rst_bw", 32'(bytes_written), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_active", 32'(load_active), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        tick();
        reset_n = 1'b1;

        // Zero-byte load still pulses once
        start_load();
        tick();
        finish_load("empty", 0);

        // Single byte, latency N+2
        ram_ready = 1'b1;
        start_load();
        tick();
        strobe(23'h000010, 8'hA5, 8'd0, 1'b1);
        @(negedge clk_sys);
        chk("lat_n0_we", 32'(ram_we), 32'd0);
        tick();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("lat_n1_we", 32'(ram_we), 32'd0);
        @(negedge clk_sys);
        chk("lat_n2_we", 32'(ram_we), 32'd1);
        chk("lat_n2_addr", 32'(ram_addr), 32'h000010);
        chk("lat_n2_din", 32'(ram_din), 32'hA5);
        finish_load("single", 1);

        // Base offset with wrap
        start_load();
        tick();
        strobe(23'h7FFFFF, 8'h3C, 8'd1, 1'b1);
        tick();
        ioctl_wr = 1'b0;
        c = 0;
        for (int i = 0; i < 10 && c == 0; i++) begin
            @(negedge clk_sys);
            if (ram_we) c = 1;
        end
        chk("wrap_we_seen", 32'(c), 32'd1);
        chk("wrap_addr", 32'(ram_addr), 32'h3FFFFF);
        finish_load("wrap", 1);

        // Back-to-back: 3 cycles per byte with ram_ready tied high
        start_load();
        ram_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i < 3) strobe(23'(32'h100 + i), 8'(32'h50 + i), 8'd0, 1'b1);
            else ioctl_wr = 1'b0;
            @(negedge clk_sys);
            if (ram_we && ram_ready) begin
                if (n < 3) t[n] = i;
                n++;
            end
        end
        chk("b2b_count", 32'(n), 32'd3);
        chk("b2b_first", 32'(t[0]), 32'd2);
        chk("b2b_gap1", 32'(t[1] - t[0]), 32'd3);
        chk("b2b_gap2", 32'(t[2] - t[1]), 32'd3);
        finish_load("b2b", 3);

        // Backpressure and overflow: 6th byte dropped
        start_load();
        ram_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            strobe(23'(32'h200 + i), 8'(i), 8'd0, i <= 5);
        end
        tick();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_hold_we", 32'(ram_we), 32'd1);
        chk("ovf_hold_din", 32'(ram_din), 32'h01);
        chk("ovf_active", 32'(load_active), 32'd1);
        finish_load("ovf", 5);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Drain after download ends
        start_load();
        ram_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            strobe(23'(32'h300 + i), 8'(32'hC0 + i), 8'd2, 1'b1);
        end
        tick();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("drain_ovf_cleared", 32'(overflow), 32'd0);
        tick();
        ram_ready = 1'b1;
        c = 0;
        la_drop = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (!load_active) la_drop = 1'b1;
            if (load_done) early = 1'b1;
            if (ram_we && ram_ready) c++;
            if (c == 4) break;
        end
        chk("drain_commits", 32'(c), 32'd4);
        chk("drain_active_held", 32'(la_drop), 32'd0);
        chk("drain_no_early_done", 32'(early), 32'd0);
        @(negedge clk_sys);
        chk("drain_gap_active", 32'(load_active), 32'd1);
        chk("drain_gap_done", 32'(load_done), 32'd0);
        @(negedge clk_sys);
        chk("drain_end_active", 32'(load_active), 32'd0);
        chk("drain_end_done", 32'(load_done), 32'd1);
        chk("drain_bw", 32'(bytes_written), 32'd4);
        @(negedge clk_sys);
        chk("drain_done_once", 32'(load_done), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        // Reset in ISSUE with 3 entries queued
        start_load();
        ram_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            strobe(23'(32'h400 + i), 8'(32'h10 + i), 8'd0, 1'b1);
        end
        tick();
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        chk("prerst_we", 32'(ram_we), 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_we", 32'(ram_we), 32'd0);
        chk("midrst_addr", 32'(ram_addr), 32'd0);
        chk("midrst_din", 32'(ram_din), 32'd0);
        chk("midrst_active", 32'(load_active), 32'd0);
        chk("midrst_bw", 32'(bytes_written), 32'd0);
        ioctl_download = 1'b0;
        exp_q.delete();
        tick();
        tick();
        reset_n   = 1'b1;
        ram_ready = 1'b1;
        c = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (ram_we) c++;
            if (load_done) n++;
        end
        chk("postrst_no_writes", 32'(c), 32'd0);
        chk("postrst_no_done", 32'(n), 32'd0);

        // Randomized traffic, occupancy kept below overflow
        start_load();
        n = 0;
        c0 = commits;
        for (int i = 0; i < 3000 && n < 40; i++) begin
            tick();
            ram_ready = 1'($urandom_range(0, 1));
            if ((n - (commits - c0)) < 4 && $urandom_range(0, 2) != 0) begin
                strobe(23'($urandom_range(0, 32'h7FFFFF)), 8'($urandom_range(0, 255)),
                       ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255)), 1'b1);
                n++;
            end else begin
                ioctl_wr = 1'b0;
            end
        end
        chk("rand_pushed", 32'(n), 32'd40);
        finish_load("rand", 40);
        chk("rand_no_ovf", 32'(overflow), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        start_load();
        ram_ready = 1'b1;
        tick();
        strobe(23'h000500, 8'hFF, 8'd0, 1'b1);
        tick();
        strobe(23'h000501, 8'hFF, 8'd0, 1'b1);
        tick();
        strobe(23'h000502, 8'h02, 8'd0, 1'b1);
        finish_load("csum", 3);
        chk("csum_value", 32'(csum_at), 32'h0200);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
